// File: rtl/pwm_sequencer.sv
// Purpose : owns the DPWM duty code and enable. It soft-starts the duty from 0 to the target,
//           slews it toward later target changes, and latches a fault shutdown.
// Latency : all outputs are registered; the state decided by this cycle's inputs appears after the next clk edge.
// Backpr. : none. Inputs are levels sampled every cycle and are never stalled.
// Ports   : clk, rst (sync, active-low); i_enable, i_target[DUTY_W], i_fault, i_fault_clr ->
//           o_duty_sel[DUTY_W], o_dpwm_en, o_ss_done (RUN), o_fault (FAULT),
//           o_state[2] (IDLE=0, RAMP=1, RUN=2, FAULT=3).
module pwm_sequencer #(
    parameter int                 DUTY_W   = 8,
    parameter int                 SS_DIV   = 1000,
    parameter int                 SLEW_DIV = 250,
    parameter logic [DUTY_W-1:0]  DUTY_MAX = DUTY_W'(230)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_enable,
    input  logic [DUTY_W-1:0] i_target,
    input  logic              i_fault,
    input  logic              i_fault_clr,
    output logic [DUTY_W-1:0] o_duty_sel,
    output logic              o_dpwm_en,
    output logic              o_ss_done,
    output logic              o_fault,
    output logic [1:0]        o_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RAMP  = 2'd1,
        ST_RUN   = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    // One prescaler is shared by the ramp and slew phases, so it is sized for the larger divider.
    localparam int DIV_MAX = (SS_DIV > SLEW_DIV) ? SS_DIV : SLEW_DIV;
    localparam int CNT_W   = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
    localparam logic [CNT_W-1:0] SS_LAST   = CNT_W'(SS_DIV - 1);
    localparam logic [CNT_W-1:0] SLEW_LAST = CNT_W'(SLEW_DIV - 1);

    state_t              state_q, state_d;
    logic [DUTY_W-1:0]   duty_q, duty_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                en_q, en_d;
    logic                ss_done_q, ss_done_d;
    logic                fault_q, fault_d;

    logic [DUTY_W-1:0]   tgt;
    logic [CNT_W-1:0]    cnt_inc;
    logic                ss_tick;
    logic                slew_tick;

    always_comb begin
        tgt       = (i_target > DUTY_MAX) ? DUTY_MAX : i_target;
        cnt_inc   = cnt_q + CNT_W'(1);
        ss_tick   = (cnt_q == SS_LAST);
        slew_tick = (cnt_q == SLEW_LAST);

        state_d = state_q;
        duty_d  = duty_q;
        cnt_d   = cnt_q;

        if (i_fault) begin
            // A fault overrides everything, including a same-cycle enable drop.
            state_d = ST_FAULT;
            duty_d  = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    duty_d = '0;
                    cnt_d  = '0;
                    if (i_enable) begin
                        state_d = ST_RAMP;
                    end
                end
                ST_RAMP: begin
                    if (!i_enable) begin
                        state_d = ST_IDLE;
                        duty_d  = '0;
                        cnt_d   = '0;
                    end else if (duty_q >= tgt) begin
                        // Checked every cycle. This covers a zero target and a target
                        // lowered below the current ramp point, which snaps down in one step.
                        state_d = ST_RUN;
                        duty_d  = tgt;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = ss_tick ? '0 : cnt_inc;
                        if (ss_tick) begin
                            duty_d = duty_q + DUTY_W'(1);
                        end
                    end
                end
                ST_RUN: begin
                    if (!i_enable) begin
                        state_d = ST_IDLE;
                        duty_d  = '0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = slew_tick ? '0 : cnt_inc;
                        // tgt is already clamped to DUTY_MAX, so stepping toward it
                        // can never wrap past 0 or DUTY_MAX.
                        if (slew_tick) begin
                            if (duty_q < tgt) begin
                                duty_d = duty_q + DUTY_W'(1);
                            end else if (duty_q > tgt) begin
                                duty_d = duty_q - DUTY_W'(1);
                            end
                        end
                    end
                end
                ST_FAULT: begin
                    duty_d = '0;
                    cnt_d  = '0;
                    // The fault stays latched until it has been acknowledged with the run request dropped.
                    if (i_fault_clr && !i_enable) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    duty_d  = '0;
                    cnt_d   = '0;
                end
            endcase
        end

        en_d      = (state_d == ST_RAMP) || (state_d == ST_RUN);
        ss_done_d = (state_d == ST_RUN);
        fault_d   = (state_d == ST_FAULT);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            duty_q    <= '0;
            cnt_q     <= '0;
            en_q      <= 1'b0;
            ss_done_q <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            duty_q    <= duty_d;
            cnt_q     <= cnt_d;
            en_q      <= en_d;
            ss_done_q <= ss_done_d;
            fault_q   <= fault_d;
        end
    end

    assign o_duty_sel = duty_q;
    assign o_dpwm_en  = en_q;
    assign o_ss_done  = ss_done_q;
    assign o_fault    = fault_q;
    assign o_state    = state_q;

endmodule

// File: tb/tb_pwm_sequencer.sv
// Purpose : randomized and directed stimulus for pwm_sequencer, compared every cycle
//           against a behavioural model plus fixed expectations at key points.
// Latency/backpressure : not applicable.
module tb_pwm_sequencer;

    localparam int DW   = 8;
    localparam int SSD  = 4;
    localparam int SLD  = 2;
    localparam int DMAX = 200;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_enable;
    logic [DW-1:0] i_target;
    logic          i_fault;
    logic          i_fault_clr;
    logic [DW-1:0] o_duty_sel;
    logic          o_dpwm_en;
    logic          o_ss_done;
    logic          o_fault;
    logic [1:0]    o_state;

    always #5 clk = ~clk;

    pwm_sequencer #(
        .DUTY_W  (DW),
        .SS_DIV  (SSD),
        .SLEW_DIV(SLD),
        .DUTY_MAX(8'd200)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_enable   (i_enable),
        .i_target   (i_target),
        .i_fault    (i_fault),
        .i_fault_clr(i_fault_clr),
        .o_duty_sel (o_duty_sel),
        .o_dpwm_en  (o_dpwm_en),
        .o_ss_done  (o_ss_done),
        .o_fault    (o_fault),
        .o_state    (o_state)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: state as a plain int (0 idle, 1 ramp, 2 run, 3 fault),
    // the duty as an int, and the edge number at which the current state was entered.
    // Step timing follows from the elapsed edges since entry, taken modulo the divider.
    int edge_n  = 0;
    int m_state = 0;
    int m_duty  = 0;
    int m_entry = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit en, input int tgt_in, input bit f, input bit clr);
        int  t;
        int  div;
        bit  tick;
        int  ns;
        edge_n++;
        t    = (tgt_in > DMAX) ? DMAX : tgt_in;
        div  = (m_state == 1) ? SSD : SLD;
        tick = ((edge_n - 1 - m_entry) % div) == (div - 1);
        ns   = m_state;
        if (!r) begin
            ns = 0; m_duty = 0;
        end else if (f) begin
            ns = 3; m_duty = 0;
        end else begin
            case (m_state)
                0: if (en) begin ns = 1; m_duty = 0; end
                1: begin
                    if (!en) begin ns = 0; m_duty = 0; end
                    else if (m_duty >= t) begin ns = 2; m_duty = t; end
                    else if (tick) m_duty++;
                end
                2: begin
                    if (!en) begin ns = 0; m_duty = 0; end
                    else if (tick) begin
                        if (m_duty < t) m_duty++;
                        else if (m_duty > t) m_duty--;
                    end
                end
                default: if (clr && !en) ns = 0;
            endcase
        end
        if (ns != m_state || !r) m_entry = edge_n;
        m_state = ns;
    endtask

    // Apply one input setting for n cycles, checking every output against the model each cycle.
    task automatic run(input bit r, input bit en, input int tgt, input bit f, input bit clr, input int n);
        for (int k = 0; k < n; k++) begin
            rst         = r;
            i_enable    = en;
            i_target    = DW'(tgt);
            i_fault     = f;
            i_fault_clr = clr;
            @(posedge clk);
            model_step(r, en, tgt, f, clr);
            #1;
            check_val("state",   32'(o_state),    32'(m_state));
            check_val("duty",    32'(o_duty_sel), 32'(m_duty));
            check_val("en",      32'(o_dpwm_en),  32'(m_state == 1 || m_state == 2));
            check_val("ss_done", 32'(o_ss_done),  32'(m_state == 2));
            check_val("fault",   32'(o_fault),    32'(m_state == 3));
        end
    endtask

    initial begin
        rst = 1'b0; i_enable = 1'b0; i_target = '0; i_fault = 1'b0; i_fault_clr = 1'b0;

        // Reset values
        run(0, 0, 0, 0, 0, 3);
        check_val("rst_state", 32'(o_state), 0);
        check_val("rst_duty",  32'(o_duty_sel), 0);
        check_val("rst_en",    32'(o_dpwm_en), 0);

        // Ramp 0 -> 10 with 4-cycle steps; RUN one cycle after duty reaches 10
        run(1, 1, 10, 0, 0, 1);
        check_val("ramp_en", 32'(o_dpwm_en), 1);
        check_val("ramp_state", 32'(o_state), 1);
        run(1, 1, 10, 0, 0, 40);
        check_val("ramp_top", 32'(o_duty_sel), 10);
        check_val("ramp_not_run", 32'(o_state), 1);
        run(1, 1, 10, 0, 0, 1);
        check_val("run_state", 32'(o_state), 2);
        check_val("run_ss_done", 32'(o_ss_done), 1);

        // Slew up to 14, then down to 7
        run(1, 1, 14, 0, 0, 10);
        check_val("slew_up", 32'(o_duty_sel), 14);
        run(1, 1, 7, 0, 0, 16);
        check_val("slew_down", 32'(o_duty_sel), 7);

        // Target above the clamp
        run(1, 1, 255, 0, 0, 400);
        check_val("clamp", 32'(o_duty_sel), 200);

        // Zero target: one cycle of RAMP, then RUN at duty 0
        run(1, 0, 0, 0, 0, 2);
        run(1, 1, 0, 0, 0, 1);
        check_val("zero_ramp", 32'(o_state), 1);
        run(1, 1, 0, 0, 0, 1);
        check_val("zero_run", 32'(o_state), 2);
        check_val("zero_duty", 32'(o_duty_sel), 0);

        // Lower the target mid-ramp at duty 5
        run(1, 0, 0, 0, 0, 2);
        run(1, 1, 20, 0, 0, 21);
        check_val("mid_ramp", 32'(o_duty_sel), 5);
        run(1, 1, 3, 0, 0, 1);
        check_val("snap_duty", 32'(o_duty_sel), 3);
        check_val("snap_state", 32'(o_state), 2);

        // Fault latch, clear rules and ramp restart
        run(1, 1, 3, 1, 0, 1);
        check_val("flt_en", 32'(o_dpwm_en), 0);
        check_val("flt_flag", 32'(o_fault), 1);
        run(1, 1, 3, 0, 1, 3);
        check_val("flt_hold", 32'(o_state), 3);
        run(1, 0, 3, 0, 1, 1);
        check_val("flt_clr", 32'(o_state), 0);
        run(1, 1, 10, 0, 0, 5);
        check_val("restart", 32'(o_duty_sel), 1);

        // Reset mid-ramp and during FAULT; fault beats enable-low
        run(0, 1, 10, 0, 0, 1);
        check_val("rst_ramp", 32'(o_state), 0);
        check_val("rst_ramp_en", 32'(o_dpwm_en), 0);
        run(1, 1, 10, 1, 0, 2);
        run(0, 1, 10, 0, 0, 1);
        check_val("rst_fault", 32'(o_state), 0);
        check_val("rst_fault_flag", 32'(o_fault), 0);
        run(1, 1, 2, 0, 0, 20);
        run(1, 0, 2, 1, 0, 1);
        check_val("flt_vs_dis", 32'(o_state), 3);
        run(1, 0, 2, 0, 1, 1);

        // Randomized segments with held inputs
        for (int s = 0; s < 300; s++) begin
            bit r_b, en_b, f_b, clr_b;
            int tgt_v;
            r_b   = ($urandom_range(0, 49) != 0);
            en_b  = ($urandom_range(0, 5) != 0);
            f_b   = ($urandom_range(0, 19) == 0);
            clr_b = ($urandom_range(0, 1) != 0);
            tgt_v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(180, 255))
                                                : int'($urandom_range(0, 40));
            run(r_b, en_b, tgt_v, f_b, clr_b, int'($urandom_range(1, 60)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
